// File: rtl/sha1_pkg.sv
// Shared SHA-1/SHA-0 constants, state/phase types and round helper functions.
package sha1_pkg;

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StFinal, StOut} sha1_state_e;
  typedef enum logic [1:0] {PhCh, PhPar1, PhMaj, PhPar2} sha1_phase_e;

  localparam logic [0:4][31:0] IV = {32'h67452301, 32'hefcdab89, 32'h98badcfe,
                                     32'h10325476, 32'hc3d2e1f0};
  localparam logic [0:3][31:0] K  = {32'h5a827999, 32'h6ed9eba1, 32'h8f1bbcdc, 32'hca62c1d6};

  // Valid for n in 0..31; a 32-bit right shift yields zero, so n = 0 is the identity.
  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] f_ch(input logic [31:0] b, c, d);
    return (b & c) | (~b & d);
  endfunction

  function automatic logic [31:0] f_par(input logic [31:0] b, c, d);
    return b ^ c ^ d;
  endfunction

  function automatic logic [31:0] f_maj(input logic [31:0] b, c, d);
    return (b & c) | (b & d) | (c & d);
  endfunction

  function automatic sha1_phase_e phase_of(input logic [6:0] rnd);
    if (rnd < 7'd20)      return PhCh;
    else if (rnd < 7'd40) return PhPar1;
    else if (rnd < 7'd60) return PhMaj;
    else                  return PhPar2;
  endfunction

endpackage

// File: rtl/sha1_wsched.sv
// 16-word message schedule: shifts in message words during load, expanded words during advance.
module sha1_wsched
  import sha1_pkg::*;
#(
  parameter int unsigned SHA0 = 0
) (
  input  logic        clk_i,
  input  logic        load_i,
  input  logic        adv_i,
  input  logic [31:0] data_i,
  output logic [31:0] w_o
);

  // w_q[15] is W[t-1], w_q[0] is W[t-16].
  logic [31:0] w_q [16];
  logic [31:0] mix;
  logic [31:0] next_w;

  always_comb begin
    mix    = w_q[13] ^ w_q[8] ^ w_q[2] ^ w_q[0];
    next_w = rotl(mix, (SHA0 != 0) ? 0 : 1);
    w_o    = load_i ? data_i : next_w;
  end

  always_ff @(posedge clk_i) begin
    if (load_i || adv_i) begin
      for (int i = 0; i < 15; i++) begin
        w_q[i] <= w_q[i+1];
      end
      w_q[15] <= w_o;
    end
  end

endmodule

// File: rtl/sha1_block_engine.sv
// One-round-per-cycle SHA-1 (or SHA-0) compression of a 512-bit block with chaining state.
module sha1_block_engine
  import sha1_pkg::*;
#(
  parameter int unsigned SHA0 = 0,
  parameter int unsigned IN_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_first,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [159:0]    out_digest,
  output logic            busy
);

  if (IN_W != 32) begin : gen_in_w_check
    $error("sha1_block_engine: IN_W must be 32");
  end

  sha1_state_e      state_q;
  logic [3:0]       cnt_q;
  logic [6:0]       rnd_q;
  logic             first_q;
  logic [0:4][31:0] h_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [31:0]      a_q, b_q, c_q, d_q, e_q;

  logic             accept;
  logic             run;
  logic [0:4][31:0] start;
  logic [0:4][31:0] h_base;
  logic [31:0]      a_s, b_s, c_s, d_s, e_s;
  logic [31:0]      f_val;
  logic [31:0]      w_cur;
  logic [31:0]      t_val;
  sha1_phase_e      phase;

  assign accept = in_valid && in_ready_q;
  assign run    = (state_q == StRun);

  sha1_wsched #(
    .SHA0 (SHA0)
  ) u_wsched (
    .clk_i  (clk),
    .load_i (accept),
    .adv_i  (run),
    .data_i (in_data),
    .w_o    (w_cur)
  );

  always_comb begin
    // Round 0 starts from IV or the stored chaining value; later rounds from the working regs.
    start  = in_first ? IV : h_q;
    h_base = first_q ? IV : h_q;
    if (state_q == StIdle) begin
      {a_s, b_s, c_s, d_s, e_s} = start;
    end else begin
      {a_s, b_s, c_s, d_s, e_s} = {a_q, b_q, c_q, d_q, e_q};
    end
    phase = phase_of(rnd_q);
    unique case (phase)
      PhCh:    f_val = f_ch(b_s, c_s, d_s);
      PhMaj:   f_val = f_maj(b_s, c_s, d_s);
      default: f_val = f_par(b_s, c_s, d_s);
    endcase
    t_val = rotl(a_s, 5) + f_val + e_s + K[phase] + w_cur;
  end

  always_ff @(posedge clk) begin
    if (accept || run) begin
      a_q <= t_val;
      b_q <= a_s;
      c_q <= rotl(b_s, 30);
      d_q <= c_s;
      e_q <= d_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      rnd_q       <= 7'd0;
      first_q     <= 1'b1;
      h_q         <= IV;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            first_q <= in_first;
            cnt_q   <= 4'd1;
            rnd_q   <= 7'd1;
            busy_q  <= 1'b1;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          if (in_valid) begin
            cnt_q <= cnt_q + 4'd1;
            rnd_q <= rnd_q + 7'd1;
            if (cnt_q == 4'd15) begin
              in_ready_q <= 1'b0;
              state_q    <= StRun;
            end
          end
        end
        StRun: begin
          if (rnd_q == 7'd79) begin
            rnd_q   <= 7'd0;
            state_q <= StFinal;
          end else begin
            rnd_q <= rnd_q + 7'd1;
          end
        end
        StFinal: begin
          h_q[0]      <= h_base[0] + a_q;
          h_q[1]      <= h_base[1] + b_q;
          h_q[2]      <= h_base[2] + c_q;
          h_q[3]      <= h_base[3] + d_q;
          h_q[4]      <= h_base[4] + e_q;
          out_valid_q <= 1'b1;
          state_q     <= StOut;
        end
        StOut: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_digest = h_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sha1_block_engine.sv
// Self-checking bench: table-driven blocks, scoreboarded digests, corner-case sequences.
module tb_sha1_block_engine;

  localparam logic [159:0] IV_C    = 160'h67452301efcdab8998badcfe10325476c3d2e1f0;
  localparam logic [159:0] ABC1    = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
  localparam logic [159:0] ABC0    = 160'h0164b8a914cd2a5e74c4f7ff082c4d97f1edf880;
  localparam logic [159:0] EMPTY1  = 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709;
  localparam logic [159:0] TWOBLK1 = 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1;

  logic         clk, rst;
  logic         in_valid, in_first, out_ready;
  logic [31:0]  in_data;
  logic         in_ready0, out_valid0, busy0;
  logic         in_ready1, out_valid1, busy1;
  logic [159:0] dig0, dig1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [159:0] sb [$];
  int           rises [$];
  logic         ov_prev = 1'b0;

  sha1_block_engine #(.SHA0(0), .IN_W(32)) dut0 (
    .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready0), .in_data (in_data),
    .in_first (in_first), .out_valid (out_valid0), .out_ready (out_ready),
    .out_digest (dig0), .busy (busy0)
  );

  sha1_block_engine #(.SHA0(1), .IN_W(32)) dut1 (
    .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready1), .in_data (in_data),
    .in_first (in_first), .out_valid (out_valid1), .out_ready (out_ready),
    .out_digest (dig1), .busy (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference compression function, independent of the RTL structure.
  function automatic logic [159:0] sha1_model(input logic [159:0] hin,
                                              input logic [0:15][31:0] blk, input bit sha0);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, tmp, x;
    for (int t = 0; t < 16; t++) w[t] = blk[t];
    for (int t = 16; t < 80; t++) begin
      x = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
      w[t] = sha0 ? x : {x[30:0], x[31]};
    end
    {a, b, c, d, e} = hin;
    for (int t = 0; t < 80; t++) begin
      if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
      else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
      else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
      else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
      tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
    end
    return {hin[159:128] + a, hin[127:96] + b, hin[95:64] + c, hin[63:32] + d, hin[31:0] + e};
  endfunction

  // Scoreboard: every digest handshake pops one expected value.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid0 && !ov_prev) rises.push_back(cyc);
      if (out_valid0 && out_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: got digest %h with no block expected", dig0);
        end else begin
          chk("digest", dig0, sb.pop_front());
        end
      end
    end
    ov_prev = out_valid0;
  end

  // Words 1..15 carry the inverse in_first, which must be ignored.
  task automatic send_block(input logic [0:15][31:0] w, input bit first, input bit gaps,
                            output int t0);
    int  i = 0;
    int  guard = 0;
    bit  rdy;
    t0 = -1;
    while (i < 16 && guard < 600) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = w[i];
      in_first = (i == 0) ? first : ~first;
      rdy      = in_ready0;
      if (in_valid && rdy && i == 0) t0 = cyc;
      @(posedge clk); #1;
      if (in_valid && rdy) i++;
      guard++;
    end
    in_valid = 1'b0;
    if (i < 16) begin
      checks++; errors++;
      $display("FAIL send_timeout: got %0d words accepted required 16", i);
    end
  endtask

  task automatic wait_out(output int c);
    int g = 0;
    while (!out_valid0 && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    c = cyc;
    if (!out_valid0) begin
      checks++; errors++;
      $display("FAIL out_timeout: got out_valid 0 required 1 within 300 cycles");
    end
  endtask

  typedef struct {
    logic [0:15][31:0] w;
    bit                first;
    int                hold;
    logic [159:0]      exp0;
    bit                chk1;
    logic [159:0]      exp1;
  } vec_t;

  initial begin
    vec_t              vecs [3];
    logic [0:15][31:0] abc_w, empty_w, tb1_w, tb2_w;
    int                t0, c, t0b;

    abc_w   = {32'h61626380, {14{32'h0}}, 32'h00000018};
    empty_w = {32'h80000000, {15{32'h0}}};
    tb1_w   = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768,
               32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d,
               32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000,
               32'h00000000};
    tb2_w   = {{15{32'h0}}, 32'h000001c0};

    vecs[0] = '{w: abc_w, first: 1'b1, hold: 0,  exp0: ABC1, chk1: 1'b1, exp1: ABC0};
    vecs[1] = '{w: tb1_w, first: 1'b1, hold: 10, exp0: sha1_model(IV_C, tb1_w, 1'b0),
                chk1: 1'b0, exp1: '0};
    vecs[2] = '{w: tb2_w, first: 1'b0, hold: 0,  exp0: TWOBLK1, chk1: 1'b0, exp1: '0};

    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_data = '0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", out_valid0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_digest", dig0, IV_C);
    chk("rst_digest_sha0", dig1, IV_C);
    chk("rst_busy_sha0", busy1, 1'b0);
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready0, 1'b1);
    chk("post_rst_in_ready_sha0", in_ready1, 1'b1);

    for (int v = 0; v < 3; v++) begin
      out_ready = (vecs[v].hold == 0);
      sb.push_back(vecs[v].exp0);
      send_block(vecs[v].w, vecs[v].first, 1'b0, t0);
      chk("run_in_ready", in_ready0, 1'b0);
      chk("run_busy", busy0, 1'b1);
      wait_out(c);
      chk("latency", c, t0 + 81);
      if (vecs[v].chk1) begin
        chk("sha0_valid", out_valid1, 1'b1);
        chk("sha0_digest", dig1, vecs[v].exp1);
      end
      for (int h = 0; h < vecs[v].hold; h++) begin
        chk("hold_valid", out_valid0, 1'b1);
        chk("hold_digest", dig0, vecs[v].exp0);
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      repeat (5) @(posedge clk);
      #1;
    end

    // Empty message with random gaps, then junk valid during RUN must not be consumed.
    sb.push_back(EMPTY1);
    send_block(empty_w, 1'b1, 1'b1, t0);
    in_valid = 1'b1; in_data = 32'hdeadbeef; in_first = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("junk_in_ready", in_ready0, 1'b0);
    repeat (20) @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out(c);
    @(posedge clk); #1;
    sb.push_back(ABC1);
    send_block(abc_w, 1'b1, 1'b0, t0);
    wait_out(c);
    @(posedge clk); #1;

    // Reset in the middle of a chained block discards it; "abc" afterwards is correct.
    send_block(abc_w, 1'b0, 1'b0, t0);
    repeat (24) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid0, 1'b0);
    chk("midrst_busy", busy0, 1'b0);
    chk("midrst_digest", dig0, IV_C);
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_in_ready", in_ready0, 1'b1);
    sb.push_back(ABC1);
    send_block(abc_w, 1'b1, 1'b0, t0);
    wait_out(c);
    chk("midrst_latency", c, t0 + 81);
    @(posedge clk); #1;

    // Back-to-back blocks with out_ready high: one digest every 82 cycles.
    rises.delete();
    sb.push_back(ABC1);
    sb.push_back(ABC1);
    send_block(abc_w, 1'b1, 1'b0, t0);
    send_block(abc_w, 1'b1, 1'b0, t0b);
    chk("b2b_accept_spacing", t0b - t0, 82);
    wait_out(c);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_pulses", rises.size(), 2);
    if (rises.size() == 2) chk("b2b_spacing", rises[1] - rises[0], 82);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
